bp_me_prefetch_issue_queue: RTL and testbench
=============================================

Name: bp_me_prefetch_issue_queue

Overview:
- Consumer end of the best-offset prefetch-address interface.
- Accepts prefetch addresses from the offset generator through a valid/ready-and handshake, discards duplicates, buffers them in a small FIFO and issues them to memory under an outstanding-request limit.
- Tracks in-flight prefetches, matches fills against them and returns matched fill addresses to the generator so its recent-request table can learn.
- Sits between the prefetch generator and the memory-side request arbiter in bp_me.

Parameters:
- daddr_width_p, 64, physical address width.
- block_offset_width_p, 6, log2 of cache-block bytes; addresses are tracked at block granularity.
- queue_els_p, 4, prefetch FIFO depth; power of 2, at least 2.
- max_outstanding_p, 2, number of in-flight tracker slots; at least 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- prefetching_active_i  in  1  generator enable; when 0, incoming requests are accepted and dropped.
- prefetch_addr_i  in  daddr_width_p  prefetch address from the generator.
- prefetch_v_i  in  1  prefetch address valid.
- prefetch_ready_and_o  out  1  ready for a prefetch address.
- mem_addr_o  out  daddr_width_p  block-aligned prefetch request address.
- mem_v_o  out  1  request valid.
- mem_ready_and_i  in  1  memory accepts the request.
- fill_v_i  in  1  a fill completed (demand or prefetch).
- fill_addr_i  in  daddr_width_p  fill address.
- fill_v_o  out  1  a matched prefetch fill, to the generator.
- fill_addr_o  out  daddr_width_p  block-aligned matched fill address.
- outstanding_o  out  $clog2(max_outstanding_p+1)  count of in-flight prefetches.

Behaviour:
- Reset is asynchronous. While reset is asserted, or on its assertion mid-operation, all FIFO and tracker entries become invalid, pointers and counts go to 0, and mem_v_o, fill_v_o and outstanding_o go to 0. mem_addr_o and fill_addr_o are 0. In-flight requests are forgotten; their later fills are ignored.
- Block address is addr[daddr_width_p-1:block_offset_width_p]. All comparisons use it. Output addresses have zero offset bits.
- prefetch_ready_and_o = !prefetching_active_i | !fifo_full. It is computed from registered state only; there is no bypass when full.
- Accept occurs on prefetch_v_i & prefetch_ready_and_o. An accepted request is dropped, with no enqueue, if:
  - prefetching_active_i is 0, or
  - its block matches any valid FIFO entry or any valid tracker entry, using pre-edge state.
  Otherwise it is enqueued at the tail.
- A fill that clears a tracker entry in the same cycle still causes a matching incoming request to be dropped, because comparison uses pre-edge state.
- mem_v_o = !fifo_empty & (outstanding < max_outstanding_p). mem_addr_o = the head entry. Both are driven from registers with no combinational path from the inputs.
- Issue occurs on mem_v_o & mem_ready_and_i: pop the head and write it into the lowest-index free tracker slot.
- Enqueue and issue in the same cycle are both performed. Occupancy is unchanged and pointers wrap modulo queue_els_p.
- On a fill (fill_v_i):
  - If the fill block matches a valid tracker entry, that entry is cleared.
  - The next cycle, fill_v_o=1 with fill_addr_o = that block, for one cycle.
  - A non-matching fill (demand fill) is ignored and fill_v_o=0.
  - At most one tracker entry holds a given block, by construction.
- Issue and a matching fill in the same cycle: outstanding = outstanding + 1 - 1. The freed slot is reusable from the next cycle.
- outstanding_o equals the number of valid tracker entries and never exceeds max_outstanding_p.
- FIFO full and tracker full at once: the queue stalls and the generator is back-pressured. No entry is ever lost except by deliberate drop.
- Latency: an accepted request on an empty queue, with free credit, presents on mem_v_o the next cycle.

Decomposition:
- Shared package bp_me_prefetch_pkg holds:
  - bp_me_prefetch_entry_s: block address plus valid bit.
  - a helper macro giving the block-address width from the two parameters.
- One natural sub-module: bp_me_prefetch_tracker, holding the in-flight slot array, lowest-free-slot allocation, match/clear logic and the count.
- The FIFO and dedup comparators stay in the top level.

Test Plan:
- Basic issue: reset, active=1. Send 0x1040 → next cycle mem_v_o=1, mem_addr_o=0x1040. Hold ready=1 → outstanding_o=1. Then fill_v_i with 0x1078 → next cycle fill_v_o=1, fill_addr_o=0x1040, outstanding_o=0.
- Dedup: send 0x2000 and then 0x2010 (same block), with mem_ready_and_i=0 → only one entry queued. After issue, send 0x2000 again while in flight → dropped; the next mem_v_o shows no duplicate.
- Credit limit: max_outstanding_p=2, mem_ready_and_i=1, no fills. Send 0x100, 0x200, 0x300 → two issues, then mem_v_o=0 with 0x300 queued. A fill of 0x100 causes 0x300 to issue the cycle after the fill.
- Full FIFO: mem_ready_and_i=0. Send 5 distinct blocks → prefetch_ready_and_o=0 after the 4th. Pulse mem_ready_and_i while v_i is held → enqueue and dequeue in the same cycle, and pointer wrap is verified.
- Disable and demand fills: active=0 → ready=1 and nothing is queued. A demand fill of an untracked address → fill_v_o stays 0.
- Reset mid-flight: two in flight and two queued. Assert reset asynchronously between clock edges → mem_v_o and outstanding_o drop to 0 immediately. Later fills of the old addresses → fill_v_o stays 0.

Source files
------------

// File: rtl/bp_me_prefetch_pkg.sv
// Shared types and defaults for the best-offset prefetch issue queue.
// Holds the block-address width macro and the tracked-entry struct.

`define BP_ME_PREFETCH_BADDR_WIDTH(daddr_mp, boff_mp) \
   ((daddr_mp) - (boff_mp))

// One tracked entry: a valid bit plus a block address of width bw.
`define BP_ME_PREFETCH_DECLARE_ENTRY_S(bw) \
   struct packed { \
      logic v; \
      logic [(bw)-1:0] addr; \
   }

package bp_me_prefetch_pkg;

   localparam int daddr_width_gp       = 64;
   localparam int block_offset_width_gp = 6;
   localparam int queue_els_gp         = 4;
   localparam int max_outstanding_gp   = 2;

   localparam int baddr_width_gp =
      `BP_ME_PREFETCH_BADDR_WIDTH(daddr_width_gp, block_offset_width_gp);

   // Entry layout for the default address geometry.
   typedef `BP_ME_PREFETCH_DECLARE_ENTRY_S(baddr_width_gp)
      bp_me_prefetch_entry_s;

endpackage

// File: rtl/bp_me_prefetch_tracker.sv
// In-flight prefetch tracker: slot array, lowest-free allocation,
// fill match/clear, duplicate probe and in-flight count.
//
// Ports:
//   i_clk, i_rst       clock, async active-high reset
//   i_alloc_v/addr     write block into lowest free slot
//   i_fill_v/addr      clear slot holding this block
//   i_probe_addr       block to look up for duplicate detection
//   o_probe_hit        probe block is in flight
//   o_fill_hit         fill matched (and clears) a slot
//   o_full             no free slot
//   o_count            number of valid slots

module bp_me_prefetch_tracker
   import bp_me_prefetch_pkg::*;
#(
   parameter int baddr_width_p     = baddr_width_gp,
   parameter int max_outstanding_p = max_outstanding_gp,
   localparam int lp_ow = $clog2(max_outstanding_p + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_alloc_v,
   input  logic [baddr_width_p-1:0] i_alloc_addr,
   input  logic                     i_fill_v,
   input  logic [baddr_width_p-1:0] i_fill_addr,
   input  logic [baddr_width_p-1:0] i_probe_addr,
   output logic                     o_probe_hit,
   output logic                     o_fill_hit,
   output logic                     o_full,
   output logic [lp_ow-1:0]         o_count
);

   typedef `BP_ME_PREFETCH_DECLARE_ENTRY_S(baddr_width_p) entry_t;

   entry_t r_slot [max_outstanding_p];

   logic [max_outstanding_p-1:0] w_free;
   logic [max_outstanding_p-1:0] w_alloc_oh;
   logic [max_outstanding_p-1:0] w_fill_oh;
   logic [max_outstanding_p-1:0] w_probe_oh;
   logic                         w_taken;

   always_comb begin
      w_free     = '0;
      w_fill_oh  = '0;
      w_probe_oh = '0;
      for (int i = 0; i < max_outstanding_p; i++) begin
         w_free[i]     = !r_slot[i].v;
         w_fill_oh[i]  = r_slot[i].v
                       && (r_slot[i].addr == i_fill_addr);
         w_probe_oh[i] = r_slot[i].v
                       && (r_slot[i].addr == i_probe_addr);
      end
   end

   // Priority pick of the lowest-index free slot.
   always_comb begin
      w_alloc_oh = '0;
      w_taken    = 1'b0;
      for (int i = 0; i < max_outstanding_p; i++) begin
         if (w_free[i] && !w_taken) begin
            w_alloc_oh[i] = 1'b1;
            w_taken       = 1'b1;
         end
      end
   end

   always_comb begin
      o_count = '0;
      for (int i = 0; i < max_outstanding_p; i++) begin
         o_count = o_count + lp_ow'(r_slot[i].v);
      end
   end

   assign o_full      = ~|w_free;
   assign o_probe_hit = |w_probe_oh;
   assign o_fill_hit  = i_fill_v & (|w_fill_oh);

   // The allocated slot was free and the cleared slot was valid
   // before the edge, so the two never target the same slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < max_outstanding_p; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         for (int i = 0; i < max_outstanding_p; i++) begin
            if (i_fill_v && w_fill_oh[i]) begin
               r_slot[i].v <= 1'b0;
            end
            if (i_alloc_v && w_alloc_oh[i]) begin
               r_slot[i] <= '{v: 1'b1, addr: i_alloc_addr};
            end
         end
      end
   end

endmodule

// File: rtl/bp_me_prefetch_issue_queue.sv
// Prefetch issue queue: dedups generator requests, buffers them in a
// FIFO, issues under an in-flight limit and reports matched fills.
//
// Ports:
//   clk_i, reset_i                 clock, async active-high reset
//   prefetching_active_i           0: requests accepted and dropped
//   prefetch_addr_i/v_i/ready_and_o  generator request handshake
//   mem_addr_o/v_o/ready_and_i     block-aligned request to memory
//   fill_v_i/addr_i                any completed fill
//   fill_v_o/addr_o                matched prefetch fill, next cycle
//   outstanding_o                  in-flight prefetch count

module bp_me_prefetch_issue_queue
   import bp_me_prefetch_pkg::*;
#(
   parameter int daddr_width_p        = daddr_width_gp,
   parameter int block_offset_width_p = block_offset_width_gp,
   parameter int queue_els_p          = queue_els_gp,
   parameter int max_outstanding_p    = max_outstanding_gp
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     prefetching_active_i,
   input  logic [daddr_width_p-1:0] prefetch_addr_i,
   input  logic                     prefetch_v_i,
   output logic                     prefetch_ready_and_o,
   output logic [daddr_width_p-1:0] mem_addr_o,
   output logic                     mem_v_o,
   input  logic                     mem_ready_and_i,
   input  logic                     fill_v_i,
   input  logic [daddr_width_p-1:0] fill_addr_i,
   output logic                     fill_v_o,
   output logic [daddr_width_p-1:0] fill_addr_o,
   output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);

   localparam int lp_bw = `BP_ME_PREFETCH_BADDR_WIDTH(
      daddr_width_p, block_offset_width_p);
   localparam int lp_pw = $clog2(queue_els_p);
   localparam int lp_cw = $clog2(queue_els_p + 1);

   typedef `BP_ME_PREFETCH_DECLARE_ENTRY_S(lp_bw) entry_t;

   entry_t           r_q [queue_els_p];
   logic [lp_pw-1:0] r_wptr;
   logic [lp_pw-1:0] r_rptr;
   logic [lp_cw-1:0] r_cnt;
   logic             r_fill_v;
   logic [lp_bw-1:0] r_fill_blk;

   logic [lp_bw-1:0] w_in_blk;
   logic [lp_bw-1:0] w_fill_blk;
   entry_t           w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_q_hit;
   logic             w_trk_hit;
   logic             w_trk_full;
   logic             w_fill_hit;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_unused_offsets;

   assign w_in_blk   =
      prefetch_addr_i[daddr_width_p-1:block_offset_width_p];
   assign w_fill_blk =
      fill_addr_i[daddr_width_p-1:block_offset_width_p];
   assign w_unused_offsets = ^{
      prefetch_addr_i[block_offset_width_p-1:0],
      fill_addr_i[block_offset_width_p-1:0]};

   assign w_full  = (r_cnt == lp_cw'(queue_els_p));
   assign w_empty = (r_cnt == '0);
   assign w_head  = r_q[r_rptr];

   // Dedup against every valid queued block, pre-edge.
   always_comb begin
      w_q_hit = 1'b0;
      for (int i = 0; i < queue_els_p; i++) begin
         if (r_q[i].v && (r_q[i].addr == w_in_blk)) begin
            w_q_hit = 1'b1;
         end
      end
   end

   // Ready comes from registered occupancy only: a full queue
   // stalls the generator even if the head issues this cycle.
   assign prefetch_ready_and_o = !prefetching_active_i | !w_full;

   assign w_accept = prefetch_v_i & prefetch_ready_and_o;
   assign w_push   = w_accept & prefetching_active_i
                   & !w_q_hit & !w_trk_hit;

   assign mem_v_o    = !w_empty & !w_trk_full;
   assign mem_addr_o = w_head.v
      ? {w_head.addr, {block_offset_width_p{1'b0}}}
      : '0;
   assign w_pop      = mem_v_o & mem_ready_and_i;

   assign fill_v_o    = r_fill_v;
   assign fill_addr_o =
      {r_fill_blk, {block_offset_width_p{1'b0}}};

   bp_me_prefetch_tracker #(
      .baddr_width_p     (lp_bw),
      .max_outstanding_p (max_outstanding_p)
   ) u_tracker (
      .i_clk        (clk_i),
      .i_rst        (reset_i),
      .i_alloc_v    (w_pop),
      .i_alloc_addr (w_head.addr),
      .i_fill_v     (fill_v_i),
      .i_fill_addr  (w_fill_blk),
      .i_probe_addr (w_in_blk),
      .o_probe_hit  (w_trk_hit),
      .o_fill_hit   (w_fill_hit),
      .o_full       (w_trk_full),
      .o_count      (outstanding_o)
   );

   // Push never lands on the popped slot: that would need the
   // queue to be both empty (no pop) and full (no push).
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < queue_els_p; i++) begin
            r_q[i] <= '0;
         end
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_pop) begin
            r_q[r_rptr].v <= 1'b0;
            r_rptr        <= r_rptr + lp_pw'(1);
         end
         if (w_push) begin
            r_q[r_wptr] <= '{v: 1'b1, addr: w_in_blk};
            r_wptr      <= r_wptr + lp_pw'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + lp_cw'(1);
            2'b01:   r_cnt <= r_cnt - lp_cw'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_fill_v   <= 1'b0;
         r_fill_blk <= '0;
      end else begin
         r_fill_v   <= w_fill_hit;
         r_fill_blk <= w_fill_hit ? w_fill_blk : '0;
      end
   end

endmodule

// File: tb/tb_bp_me_prefetch_issue_queue.sv
// Bench for bp_me_prefetch_issue_queue: vector table, corner
// sequences and random traffic against a queue-based model.

module tb_bp_me_prefetch_issue_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        act;
   logic [63:0] pa;
   logic        pv;
   logic        pr;
   logic [63:0] maddr;
   logic        mv;
   logic        mr;
   logic        fvi;
   logic [63:0] fai;
   logic        fvo;
   logic [63:0] fao;
   logic [1:0]  outs;

   always #5 clk = ~clk;

   bp_me_prefetch_issue_queue dut (
      .clk_i                (clk),
      .reset_i              (rst),
      .prefetching_active_i (act),
      .prefetch_addr_i      (pa),
      .prefetch_v_i         (pv),
      .prefetch_ready_and_o (pr),
      .mem_addr_o           (maddr),
      .mem_v_o              (mv),
      .mem_ready_and_i      (mr),
      .fill_v_i             (fvi),
      .fill_addr_i          (fai),
      .fill_v_o             (fvo),
      .fill_addr_o          (fao),
      .outstanding_o        (outs)
   );

   int total = 0;
   int bad   = 0;

   typedef logic [57:0] blk_t;

   // Model: queued blocks in order, in-flight blocks, last fill.
   blk_t mq[$];
   blk_t mt[$];
   bit   m_fv;
   blk_t m_fb;

   bit          m_ready;
   bit          m_memv;
   logic [63:0] m_maddr;
   int          m_out;

   typedef struct {
      bit          act;
      bit          v;
      logic [63:0] a;
      bit          mr;
      bit          fv;
      logic [63:0] fa;
      bit          er;
      bit          ev;
      logic [63:0] ea;
      bit          ef;
      logic [63:0] efa;
      int          eo;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      bit a_, bit v_, logic [63:0] ad, bit mr_, bit fv_,
      logic [63:0] fa_, bit er, bit ev, logic [63:0] ea,
      bit ef, logic [63:0] efa, int eo);
      vec_t r;
      r.act = a_; r.v = v_; r.a = ad; r.mr = mr_;
      r.fv = fv_; r.fa = fa_; r.er = er; r.ev = ev;
      r.ea = ea; r.ef = ef; r.efa = efa; r.eo = eo;
      return r;
   endfunction

   function automatic bit has(input blk_t q[$], input blk_t b);
      foreach (q[i]) if (q[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string n, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, got, exp);
      end
   endtask

   task automatic drive(input bit a_, input bit v_,
                        input logic [63:0] ad, input bit mr_,
                        input bit fv_, input logic [63:0] fa_);
      @(negedge clk);
      act = a_; pv = v_; pa = ad;
      mr = mr_; fvi = fv_; fai = fa_;
      #1;
   endtask

   task automatic model_eval();
      m_ready = !act || (mq.size() < 4);
      m_memv  = (mq.size() > 0) && (mt.size() < 2);
      m_maddr = (mq.size() > 0) ? {mq[0], 6'b0} : 64'h0;
      m_out   = mt.size();
   endtask

   task automatic model_step();
      blk_t b  = pa[63:6];
      blk_t fb = fai[63:6];
      bit   push;
      bit   pop;
      bit   hit = 1'b0;
      int   idx = 0;
      model_eval();
      push = pv && m_ready && act && !has(mq, b) && !has(mt, b);
      pop  = m_memv && mr;
      if (fvi) begin
         for (int i = 0; i < mt.size(); i++)
            if (mt[i] == fb) begin idx = i; hit = 1'b1; end
      end
      if (hit) mt.delete(idx);
      if (pop) mt.push_back(mq.pop_front());
      if (push) mq.push_back(b);
      m_fv = hit;
      m_fb = hit ? fb : '0;
   endtask

   task automatic model_check(input string t);
      model_eval();
      check({t, ".ready"}, 64'(pr), 64'(m_ready));
      check({t, ".mem_v"}, 64'(mv), 64'(m_memv));
      check({t, ".mem_addr"}, maddr, m_maddr);
      check({t, ".fill_v"}, 64'(fvo), 64'(m_fv));
      check({t, ".fill_addr"}, fao, {m_fb, 6'b0});
      check({t, ".outst"}, 64'(outs), 64'(m_out));
   endtask

   task automatic cyc(input string t, input bit a_, input bit v_,
                      input logic [63:0] ad, input bit mr_,
                      input bit fv_, input logic [63:0] fa_);
      drive(a_, v_, ad, mr_, fv_, fa_);
      model_check(t);
      model_step();
   endtask

   task automatic model_reset();
      mq.delete();
      mt.delete();
      m_fv = 1'b0;
      m_fb = '0;
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rf;
      rst = 1'b1; act = 1'b0; pv = 1'b0; pa = '0;
      mr = 1'b0; fvi = 1'b0; fai = '0;
      model_reset();

      // Reset state, held in reset.
      @(negedge clk); #1;
      check("rst.mem_v", 64'(mv), 64'h0);
      check("rst.outst", 64'(outs), 64'h0);
      check("rst.fill_v", 64'(fvo), 64'h0);
      check("rst.mem_addr", maddr, 64'h0);
      check("rst.fill_addr", fao, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // Basic issue, dedup, credit limit, disable.
      tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h1040,1,0,0, 1,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,0, 1,1,'h1040,0,0,0));
      tbl.push_back(mk(1,0,0,1,1,'h1078, 1,0,0,0,0,1));
      tbl.push_back(mk(1,0,0,1,0,0, 1,0,0,1,'h1040,0));
      tbl.push_back(mk(1,0,0,1,0,0, 1,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h2000,0,0,0, 1,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h2010,0,0,0, 1,1,'h2000,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,0, 1,1,'h2000,0,0,0));
      tbl.push_back(mk(1,1,'h2000,1,0,0, 1,0,0,0,0,1));
      tbl.push_back(mk(1,0,0,1,0,0, 1,0,0,0,0,1));
      tbl.push_back(mk(1,0,0,1,1,'h2000, 1,0,0,0,0,1));
      tbl.push_back(mk(1,0,0,1,0,0, 1,0,0,1,'h2000,0));
      tbl.push_back(mk(1,1,'h100,1,0,0, 1,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h200,1,0,0, 1,1,'h100,0,0,0));
      tbl.push_back(mk(1,1,'h300,1,0,0, 1,1,'h200,0,0,1));
      tbl.push_back(mk(1,0,0,1,0,0, 1,0,'h300,0,0,2));
      tbl.push_back(mk(1,0,0,1,1,'h100, 1,0,'h300,0,0,2));
      tbl.push_back(mk(1,0,0,1,0,0, 1,1,'h300,1,'h100,1));
      tbl.push_back(mk(1,0,0,1,1,'h200, 1,0,0,0,0,2));
      tbl.push_back(mk(1,0,0,1,1,'h300, 1,0,0,1,'h200,1));
      tbl.push_back(mk(1,0,0,1,0,0, 1,0,0,1,'h300,0));
      tbl.push_back(mk(0,1,'h5000,1,0,0, 1,0,0,0,0,0));
      tbl.push_back(mk(0,1,'h6000,1,1,'h7000, 1,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,0, 1,0,0,0,0,0));

      foreach (tbl[i]) begin
         string t;
         t = $sformatf("vec%0d", i);
         drive(tbl[i].act, tbl[i].v, tbl[i].a, tbl[i].mr,
               tbl[i].fv, tbl[i].fa);
         check({t, ".ready"}, 64'(pr), 64'(tbl[i].er));
         check({t, ".mem_v"}, 64'(mv), 64'(tbl[i].ev));
         check({t, ".mem_addr"}, maddr, tbl[i].ea);
         check({t, ".fill_v"}, 64'(fvo), 64'(tbl[i].ef));
         check({t, ".fill_addr"}, fao, tbl[i].efa);
         check({t, ".outst"}, 64'(outs), 64'(tbl[i].eo));
         model_step();
      end

      // Full FIFO, back-pressure, simultaneous enq/deq with wrap.
      cyc("ff1", 1, 1, 'h10000, 0, 0, 0);
      cyc("ff2", 1, 1, 'h10040, 0, 0, 0);
      cyc("ff3", 1, 1, 'h10080, 0, 0, 0);
      cyc("ff4", 1, 1, 'h100c0, 0, 0, 0);
      cyc("ff5", 1, 1, 'h10100, 0, 0, 0);
      check("ff.full_ready", 64'(pr), 64'h0);
      cyc("ff6", 1, 1, 'h10100, 1, 0, 0);
      check("ff.full_pop_ready", 64'(pr), 64'h0);
      cyc("ff7", 1, 1, 'h10100, 1, 0, 0);
      check("ff.enq_deq_ready", 64'(pr), 64'h1);
      cyc("ff8", 1, 0, 0, 0, 0, 0);
      check("ff.head_c", maddr, 64'h10080);
      check("ff.stall_v", 64'(mv), 64'h0);
      cyc("ff9", 1, 0, 0, 0, 1, 'h10000);
      cyc("ff10", 1, 0, 0, 0, 1, 'h10040);
      for (int i = 0; i < 3; i++)
         cyc($sformatf("ffd%0d", i), 1, 0, 0, 1, 0, 0);
      cyc("ffw", 1, 0, 0, 1, 0, 0);
      check("ff.wrap_head_e", maddr, 64'h10100);
      for (int i = 0; i < 3; i++)
         cyc($sformatf("ffc%0d", i), 1, 0, 0, 1, 1,
             64'h10080 + 64'(i) * 64'h40);
      cyc("ffe", 1, 0, 0, 1, 0, 0);

      // Random traffic over a small block pool to force dups.
      for (int n = 0; n < 600; n++) begin
         ra = 64'h40000 + 64'($urandom_range(0, 7)) * 64'h40
            + 64'($urandom_range(0, 63));
         rf = 64'h40000 + 64'($urandom_range(0, 7)) * 64'h40
            + 64'($urandom_range(0, 63));
         cyc($sformatf("rnd%0d", n),
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 9) < 6, ra,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) < 3, rf);
      end

      // Drain all in-flight and queued blocks.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 8; i++)
            cyc("drn", 1, 0, 0, 1, 1,
                64'h40000 + 64'(i) * 64'h40);
      end
      cyc("drn_end", 1, 0, 0, 0, 0, 0);
      check("drn.outst", 64'(outs), 64'h0);

      // Reset mid-flight: two in flight, two queued.
      cyc("mr1", 1, 1, 'h80000, 1, 0, 0);
      cyc("mr2", 1, 1, 'h80040, 1, 0, 0);
      cyc("mr3", 1, 1, 'h80080, 1, 0, 0);
      cyc("mr4", 1, 1, 'h800c0, 1, 0, 0);
      cyc("mr5", 1, 0, 0, 0, 0, 0);
      check("mr.outst_pre", 64'(outs), 64'h2);
      check("mr.head_pre", maddr, 64'h80080);
      @(negedge clk);
      act = 1'b1; pv = 1'b0; mr = 1'b1; fvi = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mr.mem_v", 64'(mv), 64'h0);
      check("mr.outst", 64'(outs), 64'h0);
      check("mr.mem_addr", maddr, 64'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cyc("mra", 1, 0, 0, 1, 1, 'h80000);
      cyc("mrb", 1, 0, 0, 1, 1, 'h80040);
      cyc("mrc", 1, 0, 0, 1, 0, 0);
      check("mr.old_fill_v", 64'(fvo), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
